// File: rtl/instr_loader_if.sv
// Byte-stream channel feeding the instruction loader.
// The source drives a byte plus a last-byte marker under valid;
// the loader answers with ready. A byte moves on a rising edge
// where valid and ready are both high.
interface instr_loader_if;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       in_last;
    logic       in_ready;

    // Byte producer (program source / testbench).
    modport master (
        output in_valid,
        output in_byte,
        output in_last,
        input  in_ready
    );

    // Byte consumer (the loader).
    modport slave (
        input  in_valid,
        input  in_byte,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/instr_loader.sv
// Instruction store writer and fetch port.
// Assembles byte pairs (high byte first) into 16-bit words and writes
// them sequentially into a 16-entry store. The fetch port returns a
// stored word only once a complete program is loaded, and only for
// addresses that belong to that program; everything else reads as NOP.
module instr_loader #(
    parameter int ADDR_W = 4,
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              start_load,
    instr_loader_if.slave     bs,
    output logic              load_busy,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count,
    input  logic [ADDR_W-1:0] read,
    output logic [WORD_W-1:0] instr,
    output logic              run
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_HI = 3'd1,
        LOAD_LO = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   wptr_reg, wptr_next;
    logic [ADDR_W:0]     count_reg, count_next;
    logic [7:0]          hi_reg;
    logic [7:0]          lo_reg;
    logic                last_reg;
    logic                ready_int;
    logic                busy_int;
    logic                done_int;
    logic                wr_en;
    logic [WORD_W-1:0]   mem_reg [DEPTH];

    // State, write pointer and word counter registers.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_reg <= IDLE;
            wptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            wptr_reg  <= wptr_next;
            count_reg <= count_next;
        end
    end

    // Next-state logic and handshake/status decode.
    always_comb begin
        state_next = state_reg;
        wptr_next  = wptr_reg;
        count_next = count_reg;
        ready_int  = 1'b0;
        busy_int   = 1'b0;
        done_int   = 1'b0;
        wr_en      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_load) begin
                    state_next = LOAD_HI;
                    wptr_next  = '0;
                    count_next = '0;
                end
            end
            LOAD_HI: begin
                ready_int = 1'b1;
                busy_int  = 1'b1;
                if (bs.in_valid) begin
                    state_next = LOAD_LO;
                end
            end
            LOAD_LO: begin
                ready_int = 1'b1;
                busy_int  = 1'b1;
                if (bs.in_valid) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                busy_int   = 1'b1;
                wr_en      = 1'b1;
                wptr_next  = wptr_reg + 1'b1;
                count_next = count_reg + 1'b1;
                // The last slot closes the load even without a last marker.
                if (last_reg || (wptr_reg == ADDR_W'(DEPTH - 1))) begin
                    state_next = DONE;
                end else begin
                    state_next = LOAD_HI;
                end
            end
            DONE: begin
                done_int = 1'b1;
                if (start_load) begin
                    state_next = LOAD_HI;
                    wptr_next  = '0;
                    count_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Byte holding registers; the last marker is only meaningful with the low byte.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            hi_reg   <= '0;
            lo_reg   <= '0;
            last_reg <= 1'b0;
        end else begin
            if ((state_reg == LOAD_HI) && bs.in_valid) begin
                hi_reg <= bs.in_byte;
            end
            if ((state_reg == LOAD_LO) && bs.in_valid) begin
                lo_reg   <= bs.in_byte;
                last_reg <= bs.in_last;
            end
        end
    end

    // Instruction store: one register per word so reset can clear every entry.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            // Word gi is written only in WRITE when the pointer selects it.
            always_ff @(posedge clk or negedge clear_n) begin
                if (!clear_n) begin
                    mem_reg[gi] <= '0;
                end else if (wr_en && (wptr_reg == ADDR_W'(gi))) begin
                    mem_reg[gi] <= {hi_reg, lo_reg};
                end
            end
        end
    endgenerate

    // Fetch port: hide the store until loaded and hide stale words past the program end.
    always_comb begin
        instr = '0;
        if (done_int && ({1'b0, read} < count_reg)) begin
            instr = mem_reg[read];
        end
    end

    assign bs.in_ready = ready_int;
    assign load_busy   = busy_int;
    assign load_done   = done_int;
    assign run         = done_int;
    assign word_count  = count_reg;

endmodule

// File: tb/tb_instr_loader.sv
// Testbench for instr_loader: directed byte streams with a scoreboard.
// Stimulus pushes expected fetch results and expected load completions
// into queues; a monitor pops and compares whenever a fetch probe is
// presented or load_done rises.
module tb_instr_loader;
    logic        clk = 1'b0;
    logic        clear_n;
    logic        start_load;
    logic        load_busy;
    logic        load_done;
    logic        run;
    logic [4:0]  word_count;
    logic [3:0]  read;
    logic [15:0] instr;

    instr_loader_if bs();

    instr_loader dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .start_load (start_load),
        .bs         (bs),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .word_count (word_count),
        .read       (read),
        .instr      (instr),
        .run        (run)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int waits = 0;
    int first_acc = -1;
    int last_acc = 0;

    logic [15:0] exp_instr_q [$];
    logic [3:0]  exp_addr_q  [$];
    logic [4:0]  exp_wc_q    [$];
    logic        probe = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Monitor: compare fetch probes and load completions against the scoreboard.
    logic        done_prev = 1'b0;
    logic [15:0] m_exp;
    logic [3:0]  m_addr;
    logic [4:0]  m_wc;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (probe) begin
                if (exp_instr_q.size() == 0) begin
                    check("fetch queue underflow", 32'd1, 32'd0);
                end else begin
                    m_exp  = exp_instr_q.pop_front();
                    m_addr = exp_addr_q.pop_front();
                    $display("fetch read=%0d instr=%h expected=%h", read, instr, m_exp);
                    check("fetch addr", 32'(read), 32'(m_addr));
                    check($sformatf("instr@%0d", m_addr), 32'(instr), 32'(m_exp));
                end
            end
            if (load_done && !done_prev) begin
                if (exp_wc_q.size() == 0) begin
                    check("unexpected load_done", 32'd1, 32'd0);
                end else begin
                    m_wc = exp_wc_q.pop_front();
                    $display("load done word_count=%0d expected=%0d", word_count, m_wc);
                    check("word_count at done", 32'(word_count), 32'(m_wc));
                    check("run at done", 32'(run), 32'd1);
                    check("in_ready at done", 32'(bs.in_ready), 32'd0);
                    check("load_busy at done", 32'(load_busy), 32'd0);
                end
            end
            done_prev = load_done;
        end
    end

    task automatic start();
        @(negedge clk);
        start_load = 1'b1;
        @(negedge clk);
        start_load = 1'b0;
    endtask

    // Present a byte and return at the negedge before the edge that takes it.
    task automatic send_byte(input logic [7:0] b, input logic last);
        int n;
        n = 0;
        @(negedge clk);
        bs.in_valid = 1'b1;
        bs.in_byte  = b;
        bs.in_last  = last;
        while (!bs.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bs.in_ready) check("in_ready timeout", 32'd0, 32'd1);
        waits += n;
        last_acc = cyc;
        if (first_acc < 0) first_acc = cyc;
    endtask

    task automatic send_word(input logic [15:0] w, input logic last);
        send_byte(w[15:8], 1'b0);
        send_byte(w[7:0], last);
    endtask

    task automatic idle();
        @(negedge clk);
        bs.in_valid = 1'b0;
        bs.in_last  = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!load_done && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!load_done) check("load_done timeout", 32'd0, 32'd1);
    endtask

    task automatic probe_read(input logic [3:0] a, input logic [15:0] e);
        @(negedge clk);
        read  = a;
        probe = 1'b1;
        exp_addr_q.push_back(a);
        exp_instr_q.push_back(e);
        @(negedge clk);
        probe = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_n     = 1'b0;
        start_load  = 1'b0;
        read        = 4'd0;
        bs.in_valid = 1'b0;
        bs.in_byte  = 8'h00;
        bs.in_last  = 1'b0;
        #12;
        check("reset in_ready", 32'(bs.in_ready), 32'd0);
        check("reset load_busy", 32'(load_busy), 32'd0);
        check("reset load_done", 32'(load_done), 32'd0);
        check("reset run", 32'(run), 32'd0);
        check("reset word_count", 32'(word_count), 32'd0);
        check("reset instr", 32'(instr), 32'd0);
        @(negedge clk);
        clear_n = 1'b1;

        // 3-word program, last marker on the final low byte.
        exp_wc_q.push_back(5'd3);
        start();
        send_word(16'h1234, 1'b0);
        send_word(16'h5678, 1'b0);
        send_word(16'h9ABC, 1'b1);
        idle();
        wait_done();
        probe_read(4'd0, 16'h1234);
        probe_read(4'd1, 16'h5678);
        probe_read(4'd2, 16'h9ABC);
        probe_read(4'd3, 16'h0000);

        // Full 16-word program without a last marker; extra bytes must stall.
        exp_wc_q.push_back(5'd16);
        start();
        for (int i = 0; i < 16; i++) send_word(16'h1000 + 16'(i), 1'b0);
        @(negedge clk);
        bs.in_byte = 8'hEE;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("in_ready after full load", 32'(bs.in_ready), 32'd0);
        end
        check("word_count after extra bytes", 32'(word_count), 32'd16);
        idle();
        wait_done();
        probe_read(4'd15, 16'h100F);
        probe_read(4'd0, 16'h1000);
        probe_read(4'd7, 16'h1007);

        // Continuous valid: one stall per word, 4 words in 12 cycles.
        exp_wc_q.push_back(5'd4);
        start();
        waits = 0;
        first_acc = -1;
        send_word(16'hA1B2, 1'b0);
        send_word(16'hC3D4, 1'b0);
        send_word(16'hE5F6, 1'b0);
        send_word(16'h0718, 1'b1);
        idle();
        check("stall cycles over 4 words", 32'(waits), 32'd3);
        check("first to last accept span", 32'(last_acc - first_acc), 32'd10);
        wait_done();
        probe_read(4'd3, 16'h0718);
        probe_read(4'd4, 16'h0000);

        // 5-word load, then a 2-word reload with the store hidden mid-load.
        exp_wc_q.push_back(5'd5);
        start();
        for (int i = 0; i < 5; i++) send_word(16'h2000 + 16'(i), i == 4);
        idle();
        wait_done();
        exp_wc_q.push_back(5'd2);
        start();
        send_word(16'h3000, 1'b0);
        send_byte(8'h30, 1'b0);
        read = 4'd0;
        #1;
        check("run during reload", 32'(run), 32'd0);
        check("load_busy during reload", 32'(load_busy), 32'd1);
        check("instr during reload", 32'(instr), 32'd0);
        send_byte(8'h01, 1'b1);
        idle();
        wait_done();
        probe_read(4'd1, 16'h3001);
        probe_read(4'd3, 16'h0000);

        // Asynchronous reset in LOAD_LO of the second word.
        start();
        send_word(16'hABCD, 1'b0);
        send_byte(8'hEF, 1'b0);
        @(posedge clk);
        #2;
        bs.in_valid = 1'b0;
        clear_n = 1'b0;
        #1;
        check("async rst in_ready", 32'(bs.in_ready), 32'd0);
        check("async rst load_busy", 32'(load_busy), 32'd0);
        check("async rst load_done", 32'(load_done), 32'd0);
        check("async rst run", 32'(run), 32'd0);
        check("async rst word_count", 32'(word_count), 32'd0);
        @(negedge clk);
        clear_n = 1'b1;
        @(negedge clk);
        check("idle after reset in_ready", 32'(bs.in_ready), 32'd0);
        check("idle after reset load_busy", 32'(load_busy), 32'd0);
        exp_wc_q.push_back(5'd2);
        start();
        send_word(16'h4444, 1'b0);
        send_word(16'h5555, 1'b1);
        idle();
        wait_done();
        probe_read(4'd0, 16'h4444);
        probe_read(4'd1, 16'h5555);
        probe_read(4'd2, 16'h0000);

        // start_load during the load and in_last with a high byte are ignored.
        exp_wc_q.push_back(5'd2);
        start();
        send_byte(8'h66, 1'b1);
        send_byte(8'h77, 1'b0);
        start_load = 1'b1;
        send_byte(8'h88, 1'b0);
        send_byte(8'h99, 1'b1);
        start_load = 1'b0;
        idle();
        wait_done();
        probe_read(4'd0, 16'h6677);
        probe_read(4'd1, 16'h8899);
        probe_read(4'd2, 16'h0000);

        repeat (3) @(negedge clk);
        check("pending load completions", 32'(exp_wc_q.size()), 32'd0);
        check("pending fetch probes", 32'(exp_instr_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
